// File: rtl/gomoku_scanner.sv
// gomoku_scanner
// Board scanner and move evaluator on the read side of the board datapath.
// Walks every cell in raster order (x fastest), registers the eight nine-cell
// line windows returned for the probed cell, then evaluates that cell one
// cycle later. It reports whether the side to move already owns a run of five
// or more, and it picks the highest-scoring empty cell as the suggested move.
//
// Ports
//   i_clk, i_rst             clock, synchronous active-low reset
//   i_start, i_color         scan request (taken only in IDLE), side to move
//   o_consider_y/x           registered probe coordinates
//   i_black_*/i_white_*      line windows for the probed cell, bit 4 = centre
//   o_busy, o_done           scan in progress / one-cycle results-valid pulse
//   o_win, o_win_y/x         five-in-a-row flag and its first stone
//   o_best_valid, o_best_y/x, o_best_score   suggested move and its score
module gomoku_scanner #(
  parameter int BOARD_SIZE = 15,
  parameter int SCORE_W    = 7
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic               i_color,
  output logic [3:0]         o_consider_y,
  output logic [3:0]         o_consider_x,
  input  logic [8:0]         i_black_y,
  input  logic [8:0]         i_black_x,
  input  logic [8:0]         i_black_yx,
  input  logic [8:0]         i_black_xy,
  input  logic [8:0]         i_white_y,
  input  logic [8:0]         i_white_x,
  input  logic [8:0]         i_white_yx,
  input  logic [8:0]         i_white_xy,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_win,
  output logic [3:0]         o_win_y,
  output logic [3:0]         o_win_x,
  output logic               o_best_valid,
  output logic [3:0]         o_best_y,
  output logic [3:0]         o_best_x,
  output logic [SCORE_W-1:0] o_best_score
);

  localparam logic [3:0] LAST = 4'(BOARD_SIZE - 1);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DRAIN,
    DONE
  } state_t;

  state_t r_state;
  state_t w_stateNext;

  logic [3:0] r_cy;
  logic [3:0] r_cx;
  logic       r_color;

  logic       r_s1Valid;
  logic [3:0] r_s1Y;
  logic [3:0] r_s1X;
  logic [8:0] r_s1BlackY;
  logic [8:0] r_s1BlackX;
  logic [8:0] r_s1BlackYx;
  logic [8:0] r_s1BlackXy;
  logic [8:0] r_s1WhiteY;
  logic [8:0] r_s1WhiteX;
  logic [8:0] r_s1WhiteYx;
  logic [8:0] r_s1WhiteXy;

  logic               r_win;
  logic [3:0]         r_winY;
  logic [3:0]         r_winX;
  logic               r_bestValid;
  logic [3:0]         r_bestY;
  logic [3:0]         r_bestX;
  logic [SCORE_W-1:0] r_bestScore;

  logic               w_accept;
  logic               w_capture;
  logic               w_lastCell;
  logic [8:0]         w_own [4];
  logic [8:0]         w_opp [4];
  logic [5:0]         w_ownSum;
  logic [5:0]         w_oppSum;
  logic               w_anyFive;
  logic               w_cellWin;
  logic               w_cellEmpty;
  logic [SCORE_W-1:0] w_cellScore;
  logic               w_unusedCentres;

  // Contiguous stones walking away from the centre: lo[3] is adjacent.
  function automatic logic [2:0] runLeft(input logic [3:0] lo);
    logic [2:0] n;
    n = 3'd0;
    if (lo[3]) begin
      n = 3'd1;
      if (lo[2]) begin
        n = 3'd2;
        if (lo[1]) begin
          n = 3'd3;
          if (lo[0]) n = 3'd4;
        end
      end
    end
    return n;
  endfunction

  // Contiguous stones walking away from the centre: hi[0] is adjacent.
  function automatic logic [2:0] runRight(input logic [3:0] hi);
    logic [2:0] n;
    n = 3'd0;
    if (hi[0]) begin
      n = 3'd1;
      if (hi[1]) begin
        n = 3'd2;
        if (hi[2]) begin
          n = 3'd3;
          if (hi[3]) n = 3'd4;
        end
      end
    end
    return n;
  endfunction

  assign w_accept   = (r_state == IDLE) && i_start;
  assign w_capture  = (r_state == SCAN);
  assign w_lastCell = (r_cy == LAST) && (r_cx == LAST);

  // Next-state and status decode; busy covers SCAN plus the DRAIN cycle.
  always_comb begin
    w_stateNext = r_state;
    o_busy      = 1'b0;
    o_done      = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_start) w_stateNext = SCAN;
      end
      SCAN: begin
        o_busy = 1'b1;
        if (w_lastCell) w_stateNext = DRAIN;
      end
      DRAIN: begin
        o_busy      = 1'b1;
        w_stateNext = DONE;
      end
      DONE: begin
        o_done      = 1'b1;
        w_stateNext = IDLE;
      end
      default: w_stateNext = IDLE;
    endcase
  end

  // State register and raster walk; coordinates sit at (0,0) outside SCAN.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state <= IDLE;
      r_cy    <= 4'd0;
      r_cx    <= 4'd0;
      r_color <= 1'b0;
    end else begin
      r_state <= w_stateNext;
      if (w_accept) r_color <= i_color;
      if (r_state == SCAN && !w_lastCell) begin
        if (r_cx == LAST) begin
          r_cx <= 4'd0;
          r_cy <= r_cy + 4'd1;
        end else begin
          r_cx <= r_cx + 4'd1;
        end
      end else begin
        r_cy <= 4'd0;
        r_cx <= 4'd0;
      end
    end
  end

  // Stage 1: windows are combinational from the probe, so capture them with
  // the coordinates that produced them on the same edge.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_s1Valid   <= 1'b0;
      r_s1Y       <= 4'd0;
      r_s1X       <= 4'd0;
      r_s1BlackY  <= 9'd0;
      r_s1BlackX  <= 9'd0;
      r_s1BlackYx <= 9'd0;
      r_s1BlackXy <= 9'd0;
      r_s1WhiteY  <= 9'd0;
      r_s1WhiteX  <= 9'd0;
      r_s1WhiteYx <= 9'd0;
      r_s1WhiteXy <= 9'd0;
    end else begin
      r_s1Valid <= w_capture;
      if (w_capture) begin
        r_s1Y       <= r_cy;
        r_s1X       <= r_cx;
        r_s1BlackY  <= i_black_y;
        r_s1BlackX  <= i_black_x;
        r_s1BlackYx <= i_black_yx;
        r_s1BlackXy <= i_black_xy;
        r_s1WhiteY  <= i_white_y;
        r_s1WhiteX  <= i_white_x;
        r_s1WhiteYx <= i_white_yx;
        r_s1WhiteXy <= i_white_xy;
      end
    end
  end

  // Stage 2: own/opponent selection, run lengths, win test and cell score.
  // Own runs count double so extending our lines beats blocking theirs.
  always_comb begin
    w_own[0] = r_color ? r_s1WhiteY  : r_s1BlackY;
    w_own[1] = r_color ? r_s1WhiteX  : r_s1BlackX;
    w_own[2] = r_color ? r_s1WhiteYx : r_s1BlackYx;
    w_own[3] = r_color ? r_s1WhiteXy : r_s1BlackXy;
    w_opp[0] = r_color ? r_s1BlackY  : r_s1WhiteY;
    w_opp[1] = r_color ? r_s1BlackX  : r_s1WhiteX;
    w_opp[2] = r_color ? r_s1BlackYx : r_s1WhiteYx;
    w_opp[3] = r_color ? r_s1BlackXy : r_s1WhiteXy;
    w_ownSum  = 6'd0;
    w_oppSum  = 6'd0;
    w_anyFive = 1'b0;
    for (int d = 0; d < 4; d++) begin
      w_ownSum = w_ownSum + 6'(runLeft(w_own[d][3:0])) + 6'(runRight(w_own[d][8:5]));
      w_oppSum = w_oppSum + 6'(runLeft(w_opp[d][3:0])) + 6'(runRight(w_opp[d][8:5]));
      if ((4'(runLeft(w_own[d][3:0])) + 4'(runRight(w_own[d][8:5]))) >= 4'd4)
        w_anyFive = 1'b1;
    end
    w_cellWin   = w_anyFive && w_own[0][4];
    w_cellEmpty = !r_s1BlackY[4] && !r_s1WhiteY[4];
    w_cellScore = SCORE_W'({w_ownSum, 1'b0}) + SCORE_W'(w_oppSum);
  end

  // Centre bits of the non-vertical windows duplicate the vertical ones.
  assign w_unusedCentres = ^{w_own[1][4], w_own[2][4], w_own[3][4],
                             w_opp[0][4], w_opp[1][4], w_opp[2][4], w_opp[3][4]};

  // Result registers: first winning stone latches, best move replaced only
  // on a strictly higher score so ties keep the earliest raster cell.
  always_ff @(posedge i_clk) begin
    if (!i_rst || w_accept) begin
      r_win       <= 1'b0;
      r_winY      <= 4'd0;
      r_winX      <= 4'd0;
      r_bestValid <= 1'b0;
      r_bestY     <= 4'd0;
      r_bestX     <= 4'd0;
      r_bestScore <= '0;
    end else if (r_s1Valid) begin
      if (w_cellWin && !r_win) begin
        r_win  <= 1'b1;
        r_winY <= r_s1Y;
        r_winX <= r_s1X;
      end
      if (w_cellEmpty && (!r_bestValid || (w_cellScore > r_bestScore))) begin
        r_bestValid <= 1'b1;
        r_bestY     <= r_s1Y;
        r_bestX     <= r_s1X;
        r_bestScore <= w_cellScore;
      end
    end
  end

  assign o_consider_y = r_cy;
  assign o_consider_x = r_cx;
  assign o_win        = r_win;
  assign o_win_y      = r_winY;
  assign o_win_x      = r_winX;
  assign o_best_valid = r_bestValid;
  assign o_best_y     = r_bestY;
  assign o_best_x     = r_bestX;
  assign o_best_score = r_bestScore;

endmodule

// File: tb/tb_gomoku_scanner.sv
// tb_gomoku_scanner
// Bench for gomoku_scanner. Holds a 15x15 board model that answers the
// scanner's probe with line windows, runs a table of board/colour cases with
// hand-computed results, and adds sequences for a stray start mid-scan, a
// start during DONE and a reset in the middle of a scan.
module tb_gomoku_scanner;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       color;
  logic [3:0] cy, cx;
  logic [8:0] bY, bX, bYx, bXy, wY, wX, wYx, wXy;
  logic       busy, done, win, bestValid;
  logic [3:0] winY, winX, bestY, bestX;
  logic [6:0] bestScore;

  logic [224:0] blackB = '0;
  logic [224:0] whiteB = '0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  gomoku_scanner #(.BOARD_SIZE(15), .SCORE_W(7)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_color(color),
    .o_consider_y(cy), .o_consider_x(cx),
    .i_black_y(bY), .i_black_x(bX), .i_black_yx(bYx), .i_black_xy(bXy),
    .i_white_y(wY), .i_white_x(wX), .i_white_yx(wYx), .i_white_xy(wXy),
    .o_busy(busy), .o_done(done), .o_win(win), .o_win_y(winY), .o_win_x(winX),
    .o_best_valid(bestValid), .o_best_y(bestY), .o_best_x(bestX),
    .o_best_score(bestScore)
  );

  // Board cell lookup; anything off the board reads as empty.
  function automatic logic cellAt(input logic [224:0] b, input int y, input int x);
    if (y < 0 || y > 14 || x < 0 || x > 14) return 1'b0;
    return b[y*15 + x];
  endfunction

  // Board datapath model: windows are combinational from the probe.
  always_comb begin
    for (int i = 0; i < 9; i++) begin
      bY[i]  = cellAt(blackB, int'(cy) + i - 4, int'(cx));
      bX[i]  = cellAt(blackB, int'(cy), int'(cx) + i - 4);
      bYx[i] = cellAt(blackB, int'(cy) + i - 4, int'(cx) + i - 4);
      bXy[i] = cellAt(blackB, int'(cy) + i - 4, int'(cx) - i + 4);
      wY[i]  = cellAt(whiteB, int'(cy) + i - 4, int'(cx));
      wX[i]  = cellAt(whiteB, int'(cy), int'(cx) + i - 4);
      wYx[i] = cellAt(whiteB, int'(cy) + i - 4, int'(cx) + i - 4);
      wXy[i] = cellAt(whiteB, int'(cy) + i - 4, int'(cx) - i + 4);
    end
  end

  typedef struct {
    string name;
    int    boardId;
    logic  col;
    int    expWin;
    int    expWinY;
    int    expWinX;
    int    expBestValid;
    int    expBestY;
    int    expBestX;
    int    expBestScore;
  } vec_t;

  vec_t vecs[8];

  task automatic setBoard(input int id);
    blackB = '0;
    whiteB = '0;
    case (id)
      1: for (int x = 3; x <= 7; x++) blackB[7*15 + x] = 1'b1;
      2: whiteB[0] = 1'b1;
      3: for (int y = 0; y < 15; y++)
           for (int x = 0; x < 15; x++)
             if ((((x / 2) + y) % 2) == 0) blackB[y*15 + x] = 1'b1;
             else whiteB[y*15 + x] = 1'b1;
      4: for (int y = 10; y <= 14; y++) blackB[y*15 + 14] = 1'b1;
      5: begin
        blackB[5*15 + 5] = 1'b1;
        whiteB[5*15 + 7] = 1'b1;
      end
      default: ;
    endcase
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Loads a board, pulses start, and follows the scan until done (bounded).
  task automatic applyStimulus(input int boardId, input logic col, input int extraStartAt,
                               input bit startInDone, output int doneAt, output int busyCycles);
    @(negedge clk);
    setBoard(boardId);
    color = col;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("busy after start", int'(busy), 1);
    checkOutput("probe after start", int'({cy, cx}), 0);
    busyCycles = busy ? 1 : 0;
    doneAt     = -1;
    for (int k = 1; k <= 400; k++) begin
      if (k == extraStartAt) start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      if (done) begin
        doneAt = k;
        break;
      end
      if (busy) busyCycles++;
    end
    if (startInDone && doneAt > 0) begin
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      checkOutput("start in DONE ignored busy", int'(busy), 0);
      checkOutput("done pulse one cycle", int'(done), 0);
    end
  endtask

  initial begin
    int doneAt;
    int busyCycles;
    int seen;

    vecs[0] = '{"empty c0",       0, 1'b0, 0,  0,  0, 1, 0,  0, 0};
    vecs[1] = '{"row5 c0",        1, 1'b0, 1,  7,  3, 1, 7,  2, 8};
    vecs[2] = '{"row5 c1",        1, 1'b1, 0,  0,  0, 1, 7,  2, 4};
    vecs[3] = '{"white00 c1",     2, 1'b1, 0,  0,  0, 1, 0,  1, 2};
    vecs[4] = '{"full c0",        3, 1'b0, 0,  0,  0, 0, 0,  0, 0};
    vecs[5] = '{"full c1",        3, 1'b1, 0,  0,  0, 0, 0,  0, 0};
    vecs[6] = '{"edge col c0",    4, 1'b0, 1, 10, 14, 1, 9, 14, 8};
    vecs[7] = '{"mixed c0",       5, 1'b0, 0,  0,  0, 1, 4,  6, 3};

    rst   = 1'b0;
    start = 1'b0;
    color = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset busy", int'(busy), 0);
    checkOutput("reset done", int'(done), 0);
    checkOutput("reset probe", int'({cy, cx}), 0);
    checkOutput("reset best", int'({bestValid, bestY, bestX, bestScore}), 0);
    checkOutput("reset win", int'({win, winY, winX}), 0);
    rst = 1'b1;

    for (int v = 0; v < 8; v++) begin
      applyStimulus(vecs[v].boardId, vecs[v].col, (v == 1) ? 50 : 0, (v == 0),
                    doneAt, busyCycles);
      checkOutput({vecs[v].name, " doneAt"}, doneAt, 226);
      checkOutput({vecs[v].name, " busyCycles"}, busyCycles, 226);
      checkOutput({vecs[v].name, " win"}, int'(win), vecs[v].expWin);
      checkOutput({vecs[v].name, " winY"}, int'(winY), vecs[v].expWinY);
      checkOutput({vecs[v].name, " winX"}, int'(winX), vecs[v].expWinX);
      checkOutput({vecs[v].name, " bestValid"}, int'(bestValid), vecs[v].expBestValid);
      checkOutput({vecs[v].name, " bestY"}, int'(bestY), vecs[v].expBestY);
      checkOutput({vecs[v].name, " bestX"}, int'(bestX), vecs[v].expBestX);
      checkOutput({vecs[v].name, " bestScore"}, int'(bestScore), vecs[v].expBestScore);
      repeat (5) @(negedge clk);
      checkOutput({vecs[v].name, " held score"}, int'(bestScore), vecs[v].expBestScore);
      checkOutput({vecs[v].name, " held win"}, int'(win), vecs[v].expWin);
    end

    // Reset in the middle of a scan discards it and no done ever follows.
    @(negedge clk);
    setBoard(0);
    color = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (100) @(negedge clk);
    checkOutput("pre-reset best valid", int'(bestValid), 1);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("midreset busy", int'(busy), 0);
    checkOutput("midreset done", int'(done), 0);
    checkOutput("midreset probe", int'({cy, cx}), 0);
    checkOutput("midreset bestValid", int'(bestValid), 0);
    checkOutput("midreset bestScore", int'(bestScore), 0);
    rst  = 1'b1;
    seen = 0;
    repeat (300) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    checkOutput("no activity after reset", seen, 0);

    // Recovery scan after the reset.
    applyStimulus(2, 1'b1, 0, 1'b0, doneAt, busyCycles);
    checkOutput("recover doneAt", doneAt, 226);
    checkOutput("recover best", int'({bestY, bestX}), 1);
    checkOutput("recover bestScore", int'(bestScore), 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
